// File: rtl/teatris_carregador_mapas_if.sv
// Map-loader bus: start request, ROM address/data, board row-write handshake and status.
// The loader side uses modport master; the ROM/board/controller side uses modport slave.
interface teatris_carregador_mapas_if;
  logic        iniciar;
  logic [1:0]  nivel;
  logic [1:0]  variante;
  logic [3:0]  endereco;
  logic [63:0] padrao;
  logic        linha_escrita;
  logic [2:0]  linha_endereco;
  logic [7:0]  linha_dado;
  logic        linha_pronto;
  logic        ocupado;
  logic        concluido;
  logic [6:0]  blocos;

  modport master (
    input  iniciar, nivel, variante, padrao, linha_pronto,
    output endereco, linha_escrita, linha_endereco, linha_dado, ocupado, concluido, blocos
  );

  modport slave (
    output iniciar, nivel, variante, padrao, linha_pronto,
    input  endereco, linha_escrita, linha_endereco, linha_dado, ocupado, concluido, blocos
  );
endinterface

// File: rtl/teatris_carregador_mapas.sv
// Loads a 64-bit map pattern from a 1-cycle ROM and writes it to the board as 8 rows; 10 cycles min.
// Row writes stall on linha_pronto=0 with row index/data held; no outputs depend combinationally on inputs.
module teatris_carregador_mapas (
  input  logic                          clock,
  input  logic                          reset_n,
  teatris_carregador_mapas_if.master    io_bus
);

  typedef enum logic [2:0] {
    OCIOSO,
    ESPERA1,
    ESPERA2,
    ESCREVE,
    FIM
  } estado_t;

  estado_t     r_estado;
  logic [3:0]  r_endereco;
  logic [63:0] r_buffer;
  logic        r_linha_escrita;
  logic [2:0]  r_linha_endereco;
  logic        r_ocupado;
  logic        r_concluido;
  logic [6:0]  r_blocos;

  logic [7:0]  w_linha_dado;
  logic        w_transfere;
  logic [3:0]  w_uns;

  function automatic logic [3:0] conta_uns(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Row r sits at bits 63-8r down to 56-8r; {~r, 3'b111} is that top bit index.
  assign w_linha_dado = r_buffer[{~r_linha_endereco, 3'b111} -: 8];
  assign w_transfere  = r_linha_escrita && io_bus.linha_pronto;
  assign w_uns        = conta_uns(w_linha_dado);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado         <= OCIOSO;
      r_endereco       <= '0;
      r_buffer         <= '0;
      r_linha_escrita  <= 1'b0;
      r_linha_endereco <= '0;
      r_ocupado        <= 1'b0;
      r_concluido      <= 1'b0;
      r_blocos         <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (io_bus.iniciar) begin
            r_endereco       <= {io_bus.variante, io_bus.nivel};
            r_ocupado        <= 1'b1;
            r_blocos         <= '0;
            r_linha_endereco <= '0;
            r_estado         <= ESPERA1;
          end
        end
        ESPERA1: begin
          r_estado <= ESPERA2;
        end
        ESPERA2: begin
          r_buffer        <= io_bus.padrao;
          r_linha_escrita <= 1'b1;
          r_estado        <= ESCREVE;
        end
        ESCREVE: begin
          if (w_transfere) begin
            r_blocos <= r_blocos + {3'b000, w_uns};
            if (r_linha_endereco == 3'd7) begin
              r_linha_escrita <= 1'b0;
              r_concluido     <= 1'b1;
              r_estado        <= FIM;
            end else begin
              r_linha_endereco <= r_linha_endereco + 3'd1;
            end
          end
        end
        FIM: begin
          r_concluido <= 1'b0;
          r_ocupado   <= 1'b0;
          r_estado    <= OCIOSO;
        end
        default: begin
          r_estado <= OCIOSO;
        end
      endcase
    end
  end

  assign io_bus.endereco       = r_endereco;
  assign io_bus.linha_escrita  = r_linha_escrita;
  assign io_bus.linha_endereco = r_linha_endereco;
  assign io_bus.linha_dado     = w_linha_dado;
  assign io_bus.ocupado        = r_ocupado;
  assign io_bus.concluido      = r_concluido;
  assign io_bus.blocos         = r_blocos;

endmodule

// File: tb/tb_teatris_carregador_mapas.sv
// Randomized scoreboard bench for the map loader: a ROM model feeds the DUT, expected rows/completions are queued at start.
module tb_teatris_carregador_mapas;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] dado;
  } linha_t;

  typedef struct {
    int         ciclo;
    logic [6:0] blocos;
    logic [3:0] ender;
  } fim_t;

  logic clock;
  logic reset_n;
  int   cyc;
  int   vectors;
  int   miscompares;

  logic [63:0] rom [16];
  linha_t      exp_row_q[$];
  fim_t        exp_fim_q[$];

  teatris_carregador_mapas_if bus();

  teatris_carregador_mapas dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io_bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // One-cycle registered ROM
  always @(posedge clock) bus.padrao <= rom[bus.endereco];

  task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, got, exp, cyc);
    end
  endtask

  task automatic falha(input string nome);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected event at cycle %0d", nome, cyc);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_endereco"},  64'(bus.endereco), 64'd0);
    chk({tag, "_escrita"},   64'(bus.linha_escrita), 64'd0);
    chk({tag, "_linha_end"}, 64'(bus.linha_endereco), 64'd0);
    chk({tag, "_dado"},      64'(bus.linha_dado), 64'd0);
    chk({tag, "_ocupado"},   64'(bus.ocupado), 64'd0);
    chk({tag, "_concluido"}, 64'(bus.concluido), 64'd0);
    chk({tag, "_blocos"},    64'(bus.blocos), 64'd0);
  endtask

  // Monitor: compares every presented row and every completion against the queues.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.linha_escrita) begin
        if (exp_row_q.size() == 0) begin
          falha("escrita_sem_esperado");
        end else begin
          chk("linha_endereco", 64'(bus.linha_endereco), 64'(exp_row_q[0].idx));
          chk("linha_dado", 64'(bus.linha_dado), 64'(exp_row_q[0].dado));
          if (bus.linha_pronto) void'(exp_row_q.pop_front());
        end
      end
      if (bus.concluido) begin
        if (exp_fim_q.size() == 0) begin
          falha("concluido_sem_esperado");
        end else begin
          fim_t f;
          f = exp_fim_q.pop_front();
          chk("latencia_concluido", 64'(cyc), 64'(f.ciclo));
          chk("blocos", 64'(bus.blocos), 64'(f.blocos));
          chk("endereco", 64'(bus.endereco), 64'(f.ender));
          chk("ocupado_em_fim", 64'(bus.ocupado), 64'd1);
          chk("linhas_pendentes", 64'(exp_row_q.size()), 64'd0);
        end
      end
    end
  end

  // Issue a start and queue the reference response; extra = stall cycles that will be inserted.
  task automatic start_load(input logic [1:0] n, input logic [1:0] v, input int extra);
    logic [3:0]  a;
    logic [63:0] pat;
    fim_t        f;
    bit          livre;
    livre = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (!bus.ocupado) begin
        livre = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    if (!livre) falha("timeout_ocioso");
    @(posedge clock); #1;
    bus.iniciar  = 1'b1;
    bus.nivel    = n;
    bus.variante = v;
    @(posedge clock); #1;
    bus.iniciar = 1'b0;
    chk("ocupado_aceite", 64'(bus.ocupado), 64'd1);
    a   = {v, n};
    pat = rom[a];
    for (int r = 0; r < 8; r++) begin
      linha_t l;
      l.idx  = 3'(r);
      l.dado = 8'((pat >> (8 * (7 - r))) & 64'hFF);
      exp_row_q.push_back(l);
    end
    f.ciclo  = cyc + 10 + extra;
    f.blocos = 7'($countones(pat));
    f.ender  = a;
    exp_fim_q.push_back(f);
  endtask

  // Runs the cycles after acceptance: optional stall at row s for len cycles, optional busy start pulse.
  task automatic run_load(input int s, input int len, input bit pulso);
    bit feito;
    feito = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      if (len > 0 && k == 2 + s) bus.linha_pronto = 1'b0;
      if (k == 2 + s + len) bus.linha_pronto = 1'b1;
      if (pulso && k == 5) begin
        bus.iniciar = 1'b1;
        bus.nivel   = 2'd2;
      end
      if (pulso && k == 6) bus.iniciar = 1'b0;
      if (!bus.ocupado) begin
        feito = 1'b1;
        break;
      end
    end
    bus.linha_pronto = 1'b1;
    if (!feito) falha("timeout_carga");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    for (int i = 0; i < 16; i++) rom[i] = {$urandom, $urandom};
    rom[13] = 64'h1818_0000_0000_0000;
    rom[0]  = 64'h0206_0000_0000_0000;
    rom[1]  = 64'h0000_0000_0000_6030;
    rom[12] = 64'h0000_0000_1800_0000;

    reset_n          = 1'b0;
    bus.iniciar      = 1'b0;
    bus.nivel        = 2'd0;
    bus.variante     = 2'd0;
    bus.linha_pronto = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_zero("idle");
    end

    // Fixed-latency load of address 13
    start_load(2'd1, 2'd3, 0);
    run_load(0, 0, 1'b0);
    // Address 0
    start_load(2'd0, 2'd0, 0);
    run_load(0, 0, 1'b0);
    // Back-pressure: 3 stall cycles at row 6 of address 1
    start_load(2'd1, 2'd0, 3);
    run_load(6, 3, 1'b0);
    // Busy ignore: start pulse with nivel=2 during ESCREVE of address 12
    start_load(2'd0, 2'd3, 0);
    run_load(0, 0, 1'b1);
    repeat (3) @(posedge clock);
    #1 chk("sem_inicio_enfileirado", 64'(bus.ocupado), 64'd0);

    // Mid-operation reset while row 3 is pending
    start_load(2'd1, 2'd3, 0);
    repeat (5) @(posedge clock);
    #1 chk("linha_pendente_antes_reset", 64'(bus.linha_endereco), 64'd3);
    #1 reset_n = 1'b0;
    exp_row_q.delete();
    exp_fim_q.delete();
    #1 check_zero("reset_assinc");
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("pos_reset_escrita", 64'(bus.linha_escrita), 64'd0);
      chk("pos_reset_ocupado", 64'(bus.ocupado), 64'd0);
    end
    @(posedge clock); #1;
    start_load(2'd1, 2'd3, 0);
    run_load(0, 0, 1'b0);

    // Randomized loads with random stalls
    for (int t = 0; t < 24; t++) begin
      logic [1:0] n, v;
      int s, len;
      n   = 2'($urandom_range(0, 3));
      v   = 2'($urandom_range(0, 3));
      s   = $urandom_range(0, 7);
      len = $urandom_range(0, 3);
      start_load(n, v, len);
      run_load(s, len, 1'b0);
    end

    repeat (4) @(posedge clock);
    #1 chk("filas_vazias", 64'(exp_row_q.size() + exp_fim_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
